serpent_ip_loader: RTL and testbench
====================================

Name: serpent_ip_loader

Overview:
- Ingress stage of the Serpent datapath.
- Accepts a 128-bit plaintext block as four 32-bit words over a valid/ready stream and assembles them.
- Applies the Serpent initial permutation (IP), the exact inverse of the final-permutation stage, and presents the block on a registered valid/ready output to the round pipeline.
- Invariant: FP(IP(x)) = x for every 128-bit x.

Parameters:
- MSW_FIRST, 1: 1 = first accepted word is bits [127:96]; 0 = first word is bits [31:0].
- WORD_W, 32: ingress word width. Only 32 is supported; any other value is an elaboration error.

Ports:
- i_clk      input   1    clock, rising edge
- i_rst_n    input   1    asynchronous active-low reset
- i_flush    input   1    synchronous abort: discard partial block and output register
- i_valid    input   1    ingress word valid
- o_ready    output  1    ingress word accepted when i_valid & o_ready
- i_data     input   32   ingress word
- o_valid    output  1    permuted block valid
- i_ready    input   1    downstream accepts block when o_valid & i_ready
- o_data     output  128  permuted block (IP applied)
- o_busy     output  1    high while word count != 0 or o_valid

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - word count = 0, assembly register = 0, o_valid = 0, o_data = 0.
  - o_ready = 1 after reset; o_busy = 0.
- Assembly:
  - 2-bit counter cnt, 0..3, increments on each ingress handshake.
  - Words 0..2 are written into a 96-bit assembly register.
  - Word 3 bypasses the assembly register.
  - The full block {w0,w1,w2,w3} (MSW_FIRST=1) or {w3,w2,w1,w0} (MSW_FIRST=0) is permuted and loaded into o_data in the same edge.
  - cnt wraps 3 -> 0.
- Permutation: with x = assembled block, o_data[4m+j] = x[127-32j-m] for j in 0..3, m in 0..31. Pure wiring, no logic levels.
- Latency: o_valid rises on the clock edge that accepts word 3, so the block is visible the cycle after the 4th handshake. Minimum period is 4 cycles per block at full throughput.
- States, implicit in cnt and o_valid:
  - FILL: o_valid = 0.
  - FILL_HOLD: o_valid = 1, cnt < 3. Ingress continues filling words 0..2 while the output waits.
  - STALL: o_valid = 1, cnt = 3, i_ready = 0.
- Ready rule: o_ready = !(cnt==3 & o_valid & !i_ready).
  - Word 3 is accepted in the same cycle the held block drains (simultaneous load and unload). The new block replaces o_data with no bubble.
- o_valid clears on an output handshake unless a new block loads in the same edge, in which case it stays 1.
- o_data and o_valid are stable while o_valid & !i_ready (AXI-style hold).
- i_flush (highest priority below reset): next edge sets cnt = 0, o_valid = 0. The assembly register need not clear. An ingress handshake in the flush cycle is discarded. o_ready is still computed normally.
- Reset mid-block: the partial block is lost and no output is produced.
- X on i_data while i_valid = 0 must not propagate to o_data.

Decomposition:
- serpent_pkg holds:
  - SERPENT_BLK_W = 128, SERPENT_WORD_W = 32, SERPENT_WORDS = 4.
  - Function serpent_ip(input [127:0]) returning the permuted vector.
  - Companion serpent_fp for benches and the existing FP stage, so both directions share one index formula.
- Sub-module: serpent_ip, a pure-combinational 128-bit wiring block instantiated once on the load path. All sequential logic stays in serpent_ip_loader.

Test Plan:
- MSW_FIRST=1:
  - Words 80000000,0,0,0 -> one cycle after 4th handshake o_valid=1, o_data=128'h1.
  - Words 0,0,0,1 -> o_data=128'h8000_0000_0000_0000_0000_0000_0000_0000.
  - Words 00000001,0,0,0 -> o_data=128'h1000_0000_0000_0000_0000_0000_0000_0000.
- Random 1000 blocks, random i_valid/i_ready gaps -> every output equals serpent_ip(block); serpent_fp(o_data) == input block; order preserved; no drops or duplicates.
- i_ready held 0 after a block emerges; feed 4 more words -> o_ready drops only on word 3, o_data stable. Raise i_ready with word 3 valid -> the next block appears the following cycle with o_valid never deasserting.
- i_flush after 2 words, then 4 fresh words -> exactly one output equal to serpent_ip of the fresh block. o_busy=0 the cycle after flush.
- Assert i_rst_n=0 asynchronously mid-cycle with o_valid=1 and cnt=2 -> o_valid, o_data, o_busy go 0 immediately. Post-reset first block is correct.
- MSW_FIRST=0: words 1,0,0,0 -> o_data=128'h8000_0000_0000_0000_0000_0000_0000_0000.

Source files
------------

// File: rtl/serpent_pkg.sv
// rtl/serpent_pkg.sv - shared Serpent widths and IP/FP bit-permutation helpers
package serpent_pkg;

    localparam int SERPENT_BLK_W  = 128;
    localparam int SERPENT_WORD_W = 32;
    localparam int SERPENT_WORDS  = 4;

    // Initial permutation: out[4m+j] = in[127-32j-m]
    function automatic logic [127:0] serpent_ip(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int j = 0; j < 4; j++) begin
            for (int m = 0; m < 32; m++) begin
                y[4*m+j] = x[127-32*j-m];
            end
        end
        return y;
    endfunction

    // Final permutation: same index formula, opposite direction, so FP(IP(x)) = x
    function automatic logic [127:0] serpent_fp(input logic [127:0] y);
        logic [127:0] x;
        x = '0;
        for (int j = 0; j < 4; j++) begin
            for (int m = 0; m < 32; m++) begin
                x[127-32*j-m] = y[4*m+j];
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/serpent_ip.sv
// rtl/serpent_ip.sv - combinational Serpent initial permutation (pure wiring)
module serpent_ip (
    input  logic [127:0] x,
    output logic [127:0] y
);

    // Constant-index bit shuffle; no gates on this path
    assign y = serpent_pkg::serpent_ip(x);

endmodule

// File: rtl/serpent_ip_loader.sv
// rtl/serpent_ip_loader.sv - assembles four ingress words, applies IP, holds block for the round pipeline
module serpent_ip_loader #(
    parameter int MSW_FIRST = 1,
    parameter int WORD_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [127:0]      o_data,
    output logic              o_busy
);

    import serpent_pkg::*;

    localparam logic [1:0] LAST = 2'(SERPENT_WORDS - 1);

    generate
        if (WORD_W != SERPENT_WORD_W) begin : g_bad_word_w
            $error("serpent_ip_loader: WORD_W must be 32");
        end
    endgenerate

    logic [1:0]                 cnt;
    logic [95:0]                asm_q;
    logic [1:0]                 slot;
    logic [SERPENT_BLK_W-1:0]   blk;
    logic [SERPENT_BLK_W-1:0]   blk_ip;
    logic                       accept;
    logic                       load;
    logic                       unload;

    // Word 3 skips the assembly register and joins the block straight from i_data
    generate
        if (MSW_FIRST != 0) begin : g_msw
            assign blk  = {asm_q, i_data};
            assign slot = 2'd2 - cnt;
        end else begin : g_lsw
            assign blk  = {i_data, asm_q};
            assign slot = cnt;
        end
    endgenerate

    serpent_ip u_ip (
        .x (blk),
        .y (blk_ip)
    );

    // Only the last word can be refused: while the held block is stuck and a new one would replace it
    always_comb begin
        o_ready = 1'b1;
        if ((cnt == LAST) && o_valid && !i_ready) begin
            o_ready = 1'b0;
        end
    end

    assign accept = i_valid & o_ready;
    assign load   = accept & (cnt == LAST);
    assign unload = o_valid & i_ready;
    assign o_busy = (cnt != 2'd0) | o_valid;

    // Word counter, assembly slots and output register; flush drops partial and held blocks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= 2'd0;
            asm_q   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_flush) begin
            cnt     <= 2'd0;
            o_valid <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= cnt + 2'd1;
            end
            if (accept && (cnt != LAST)) begin
                case (slot)
                    2'd0:    asm_q[31:0]  <= i_data;
                    2'd1:    asm_q[63:32] <= i_data;
                    2'd2:    asm_q[95:64] <= i_data;
                    default: ;
                endcase
            end
            if (load) begin
                o_data  <= blk_ip;
                o_valid <= 1'b1;
            end else if (unload) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serpent_ip_loader.sv
// tb/tb_serpent_ip_loader.sv - self-checking bench for serpent_ip_loader
module tb_serpent_ip_loader;

    import serpent_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         valid = 1'b0;
    logic         ready = 1'b0;
    logic [31:0]  data = '0;
    logic         o_ready, o_valid, o_busy;
    logic [127:0] o_data;

    logic         l_valid = 1'b0;
    logic         l_iready = 1'b1;
    logic         l_flush = 1'b0;
    logic [31:0]  l_data = '0;
    logic         l_oready, l_ovalid, l_obusy;
    logic [127:0] l_odata;

    int checks = 0;
    int fails = 0;
    int n_recv = 0;
    bit rnd_en = 1'b0;

    logic [31:0]  part[$];
    logic [127:0] pend[$];

    always #5 clk = ~clk;

    serpent_ip_loader #(.MSW_FIRST(1), .WORD_W(32)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_valid (valid),
        .o_ready (o_ready),
        .i_data  (data),
        .o_valid (o_valid),
        .i_ready (ready),
        .o_data  (o_data),
        .o_busy  (o_busy)
    );

    serpent_ip_loader #(.MSW_FIRST(0), .WORD_W(32)) u_lsb (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (l_flush),
        .i_valid (l_valid),
        .o_ready (l_oready),
        .i_data  (l_data),
        .o_valid (l_ovalid),
        .i_ready (l_iready),
        .o_data  (l_odata),
        .o_busy  (l_obusy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference IP in bit-slice form: nibble m collects bit (31-m) of words 0..3 of the block
    function automatic logic [127:0] ref_ip(input logic [127:0] x);
        logic [31:0]  w [4];
        logic [127:0] y;
        for (int j = 0; j < 4; j++) w[j] = x[127-32*j -: 32];
        for (int m = 0; m < 32; m++) y[4*m +: 4] = {w[3][31-m], w[2][31-m], w[1][31-m], w[0][31-m]};
        return y;
    endfunction

    // Transaction model: partial word list and queue of blocks waiting at the output
    always @(posedge clk or negedge rst_n) begin : model
        bit rdy;
        if (!rst_n || flush) begin
            part.delete();
            pend.delete();
        end else begin
            rdy = !(part.size() == 3 && pend.size() > 0 && !ready);
            if (pend.size() > 0 && ready) begin
                void'(pend.pop_front());
                n_recv++;
            end
            if (valid && rdy) begin
                part.push_back(data);
                if (part.size() == 4) begin
                    pend.push_back({part[0], part[1], part[2], part[3]});
                    part.delete();
                end
            end
        end
    end

    // Every cycle: compare handshake signals and held block against the model
    always @(negedge clk) begin : monitor
        bit ev;
        ev = pend.size() > 0;
        chk("o_valid", o_valid, ev);
        chk("o_ready", o_ready, !(part.size() == 3 && ev && !ready));
        chk("o_busy", o_busy, (part.size() != 0) || ev);
        if (ev) begin
            chk("o_data", o_data, ref_ip(pend[0]));
            chk("fp_roundtrip", serpent_fp(o_data), pend[0]);
        end
    end

    // Randomised downstream back-pressure
    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit hs;
        int guard;
        guard = 0;
        valid = 1'b1;
        data  = w;
        do begin
            @(negedge clk);
            hs = o_ready;
            step();
            guard++;
        end while (!hs && guard < 50);
        if (!hs) begin
            checks++;
            fails++;
            $display("FAIL send_word_timeout got=%0d expected=1", hs);
        end
        valid = 1'b0;
        data  = 'x;
    endtask

    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        send_word(a);
        send_word(b);
        send_word(c);
        send_word(d);
    endtask

    task automatic l_send4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        logic [31:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int k = 0; k < 4; k++) begin
            l_valid = 1'b1;
            l_data  = w[k];
            step();
        end
        l_valid = 1'b0;
        l_data  = 'x;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  bw [4];
        logic [127:0] da, blk;
        int nb, guard;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready", o_ready, 1);
        chk("rst_o_busy", o_busy, 0);
        chk("rst_o_data", o_data, 0);
        chk("model_pin", ref_ip(128'h1), 128'h8000_0000_0000_0000_0000_0000_0000_0000);

        // Directed MSW_FIRST=1 vectors
        ready = 1'b1;
        send4(32'h8000_0000, 0, 0, 0);
        chk("lit1_valid", o_valid, 1);
        chk("lit1_data", o_data, 128'h1);
        send4(0, 0, 0, 32'h1);
        chk("lit2_data", o_data, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send4(32'h1, 0, 0, 0);
        chk("lit3_data", o_data, 128'h1000_0000_0000_0000_0000_0000_0000_0000);
        step();

        // Stall: block held, next block fills, last word waits, then load-and-unload together
        ready = 1'b0;
        send4($urandom, $urandom, $urandom, $urandom);
        chk("stall_valid", o_valid, 1);
        for (int k = 0; k < 4; k++) bw[k] = $urandom;
        send_word(bw[0]);
        chk("stall_ready_w0", o_ready, 1);
        send_word(bw[1]);
        send_word(bw[2]);
        chk("stall_ready_w3", o_ready, 0);
        da = o_data;
        valid = 1'b1;
        data  = bw[3];
        step();
        step();
        chk("stall_hold_data", o_data, da);
        chk("stall_hold_ready", o_ready, 0);
        ready = 1'b1;
        step();
        valid = 1'b0;
        data  = 'x;
        chk("swap_valid", o_valid, 1);
        chk("swap_data", o_data, ref_ip({bw[0], bw[1], bw[2], bw[3]}));
        step();

        // Flush after two words, with a word offered in the flush cycle
        send_word($urandom);
        send_word($urandom);
        flush = 1'b1;
        valid = 1'b1;
        data  = $urandom;
        step();
        flush = 1'b0;
        valid = 1'b0;
        data  = 'x;
        chk("flush_busy", o_busy, 0);
        chk("flush_valid", o_valid, 0);
        nb = n_recv;
        send4(32'h8000_0000, 0, 0, 0);
        chk("flush_data", o_data, 128'h1);
        step();
        step();
        chk("flush_count", n_recv - nb, 1);

        // Random traffic with gaps on both sides
        rnd_en = 1'b1;
        nb = n_recv;
        for (int b = 0; b < 1000; b++) begin
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) step();
                send_word($urandom);
            end
        end
        rnd_en = 1'b0;
        step();
        ready = 1'b1;
        guard = 0;
        while (pend.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("rand_drained", pend.size(), 0);
        chk("rand_count", n_recv - nb, 1000);

        // Async reset mid-cycle with a held block and two words buffered
        ready = 1'b0;
        send4($urandom, $urandom, $urandom, $urandom);
        send_word($urandom);
        send_word($urandom);
        chk("pre_rst_valid", o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_data", o_data, 0);
        chk("arst_busy", o_busy, 0);
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) bw[k] = $urandom;
        blk = {bw[0], bw[1], bw[2], bw[3]};
        send4(bw[0], bw[1], bw[2], bw[3]);
        chk("post_rst_data", o_data, ref_ip(blk));
        step();

        // MSW_FIRST=0 instance
        l_send4(32'h1, 0, 0, 0);
        chk("lsb1_valid", l_ovalid, 1);
        chk("lsb1_data", l_odata, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        l_send4(0, 0, 0, 32'h8000_0000);
        chk("lsb2_data", l_odata, 128'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
